// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames from MOSI and serialises RAM read
// data onto MISO. Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output.
module spi_slave_param #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned TX_WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              tx_timeout
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned WAIT_W  = $clog2(TX_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle, StChkCmd, StWrite, StReadAddr, StReadData, StTxWait, StTxSend, StHold
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                raddr_done_q, raddr_done_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                miso_q, miso_d;
    logic                tx_timeout_q, tx_timeout_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                frame_err_q, frame_err_d;
`endif

    logic [FRAME_W-1:0]  shift_in;
    logic                in_shift;
    logic                last_bit;

    assign shift_in = MSB_FIRST ? {shift_q[FRAME_W-2:0], MOSI} : {MOSI, shift_q[FRAME_W-1:1]};
    assign in_shift = (state_q == StWrite) || (state_q == StReadAddr) || (state_q == StReadData);
    assign last_bit = (cnt_q == CNT_W'(FRAME_W - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        raddr_done_d = raddr_done_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        miso_d       = 1'b0;
        tx_timeout_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_err_d  = 1'b0;
`endif
        // Deselect wins over everything else, including a last bit or tx_valid on the same edge.
        if (SS_n && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = in_shift;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (!SS_n) state_d = StChkCmd;
                end
                StChkCmd: begin
                    cnt_d = '0;
                    if (!MOSI)             state_d = StWrite;
                    else if (raddr_done_q) state_d = StReadData;
                    else                   state_d = StReadAddr;
                end
                StWrite, StReadAddr, StReadData: begin
                    shift_d = shift_in;
                    if (last_bit) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err_d = shift_in[FRAME_W-1] != (state_q != StWrite);
`endif
                        if (state_q == StReadData) begin
                            raddr_done_d = 1'b0;
                            wait_d       = '0;
                            state_d      = StTxWait;
                        end else begin
                            if (state_q == StReadAddr) raddr_done_d = 1'b1;
                            state_d = StHold;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StTxWait: begin
                    if (tx_valid) begin
                        miso_d  = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
                        tx_d    = MSB_FIRST ? (tx_data << 1) : (tx_data >> 1);
                        cnt_d   = CNT_W'(1);
                        state_d = StTxSend;
                    end else if (wait_q == WAIT_W'(TX_WAIT_MAX - 1)) begin
                        tx_timeout_d = 1'b1;
                        state_d      = StHold;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                StTxSend: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        state_d = StHold;
                    end else begin
                        miso_d = MSB_FIRST ? tx_q[DATA_W-1] : tx_q[0];
                        tx_d   = MSB_FIRST ? (tx_q << 1) : (tx_q >> 1);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                StHold: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wait_q       <= '0;
            raddr_done_q <= 1'b0;
            shift_q      <= '0;
            tx_q         <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            miso_q       <= 1'b0;
            tx_timeout_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            raddr_done_q <= raddr_done_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            miso_q       <= miso_d;
            tx_timeout_q <= tx_timeout_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign MISO       = miso_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign tx_timeout = tx_timeout_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    assign frame_err  = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an LSB-first 8-bit instance and an MSB-first 16-bit instance,
// checked against a frame-level model of receive data, raddr_done and MISO streams.
module tb_spi_slave_param;

    localparam int DW  = 8;
    localparam int FW  = DW + 2;
    localparam int DW2 = 16;
    localparam int FW2 = DW2 + 2;
    localparam int TWM = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
    logic [DW-1:0]  tx_data = '0;
    logic           MISO, rx_valid, tx_timeout;
    logic [FW-1:0]  rx_data;
    logic           ss_n2 = 1'b1, mosi2 = 1'b0, tx_valid2 = 1'b0;
    logic [DW2-1:0] tx_data2 = '0;
    logic           miso2, rx_valid2, tx_timeout2;
    logic [FW2-1:0] rx_data2;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic           frame_err, frame_err2;
`endif

    int checks = 0;
    int errors = 0;
    int obs_rxv, obs_miso, obs_rxv2, obs_miso2;
    logic          model_raddr;
    logic [FW-1:0] model_rx;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(DW), .MSB_FIRST(1'b0), .TX_WAIT_MAX(TWM)) u_dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .tx_valid(tx_valid),
        .tx_data(tx_data), .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_timeout(tx_timeout)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    spi_slave_param #(.DATA_W(DW2), .MSB_FIRST(1'b1), .TX_WAIT_MAX(TWM)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n2), .MOSI(mosi2), .tx_valid(tx_valid2),
        .tx_data(tx_data2), .MISO(miso2), .rx_valid(rx_valid2), .rx_data(rx_data2),
        .tx_timeout(tx_timeout2)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(frame_err2)
`endif
    );

    // Sample point is the falling edge; inputs change right after sampling.
    task automatic tick();
        @(negedge clk);
        obs_rxv  += int'(rx_valid);
        obs_miso += int'(MISO);
        obs_rxv2  += int'(rx_valid2);
        obs_miso2 += int'(miso2);
    endtask

    task automatic start_frame(input logic dir);
        tick(); SS_n = 1'b0; MOSI = 1'($urandom);
        tick(); MOSI = dir;
    endtask

    task automatic shift_bits(input logic [FW-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            tick(); MOSI = v[i];
        end
    endtask

    task automatic end_frame();
        tick(); SS_n = 1'b1; MOSI = 1'b0;
        tick();
    endtask

    task automatic start2(input logic dir);
        tick(); ss_n2 = 1'b0; mosi2 = 1'($urandom);
        tick(); mosi2 = dir;
    endtask

    task automatic shift2(input logic [FW2-1:0] v);
        for (int i = 0; i < FW2; i++) begin
            tick(); mosi2 = v[FW2-1-i];
        end
    endtask

    task automatic end2();
        tick(); ss_n2 = 1'b1; mosi2 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++;
        if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", MISO); end
        checks++;
        if (tx_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", tx_timeout); end
        checks++;
        if (rx_data2 !== '0) begin errors++; $display("FAIL reset_rx_data16: got %h want 0", rx_data2); end
        checks++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++;
`endif
        rst_n = 1'b1;
        model_raddr = 1'b0;
        model_rx = '0;
    endtask

    task automatic test_write();
        logic [FW-1:0] v;
        for (int r = 0; r < 5; r++) begin
            v = (r == 0) ? 10'h0A5 : {1'b0, 9'($urandom)};
            obs_rxv = 0; obs_miso = 0;
            tx_valid = 1'b1; tx_data = 8'($urandom);
            start_frame(1'b0);
            shift_bits(v, FW);
            tick();
            if (rx_valid !== 1'b1 || rx_data !== v) begin
                errors++; $display("FAIL write_rx: got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, v);
            end
            checks++;
            tick();
            if (rx_valid !== 1'b0) begin errors++; $display("FAIL write_pulse_len: got %b want 0", rx_valid); end
            checks++;
            end_frame();
            tx_valid = 1'b0;
            if (obs_rxv != 1 || obs_miso != 0) begin
                errors++; $display("FAIL write_counts: got rxv=%0d miso=%0d want 1 0", obs_rxv, obs_miso);
            end
            checks++;
            model_rx = v;
        end
    endtask

    task automatic test_read();
        logic [FW-1:0] a, d;
        logic [DW-1:0] t;
        logic          exp;
        int            dly;
        for (int r = 0; r < 4; r++) begin
            a   = (r == 0) ? 10'h233 : {2'b10, 8'($urandom)};
            d   = (r == 0) ? 10'h300 : {2'b11, 8'($urandom)};
            t   = (r == 0) ? 8'hC6 : 8'($urandom);
            dly = (r == 0) ? 1 : int'($urandom_range(0, 6));
            // Address phase only if the model says no address is pending.
            if (!model_raddr) begin
                obs_miso = 0;
                start_frame(1'b1);
                shift_bits(a, FW);
                tick();
                if (rx_valid !== 1'b1 || rx_data !== a) begin
                    errors++; $display("FAIL raddr_rx: got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, a);
                end
                checks++;
                tx_valid = 1'b1; tx_data = 8'hFF;
                repeat (3) tick();
                tx_valid = 1'b0;
                end_frame();
                if (obs_miso != 0) begin errors++; $display("FAIL raddr_no_send: got %0d want 0", obs_miso); end
                checks++;
                model_raddr = 1'b1;
            end
            start_frame(1'b1);
            shift_bits(d, FW);
            tick();
            if (rx_valid !== 1'b1 || rx_data !== d) begin
                errors++; $display("FAIL rdata_rx: got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, d);
            end
            checks++;
            model_raddr = 1'b0;
            model_rx = d;
            repeat (dly) tick();
            tx_valid = 1'b1; tx_data = t;
            for (int i = 0; i < DW + 3; i++) begin
                tick();
                exp = (i < DW) ? t[i] : 1'b0;
                if (MISO !== exp) begin errors++; $display("FAIL rdata_miso[%0d]: got %b want %b", i, MISO, exp); end
                checks++;
                tx_valid = (i == 1);
                tx_data = ~t;
            end
            tx_valid = 1'b0;
            end_frame();
        end
    endtask

    task automatic test_abort();
        logic [FW-1:0] v;
        obs_rxv = 0;
        v = FW'($urandom);
        start_frame(1'b0);
        shift_bits(v, 5);
        tick(); SS_n = 1'b1;
        tick();
        if (rx_valid !== 1'b0 || rx_data !== model_rx) begin
            errors++; $display("FAIL abort_mid: got v=%b d=%h want v=0 d=%h", rx_valid, rx_data, model_rx);
        end
        checks++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_frame_err: got %b want 1", frame_err); end
        checks++;
        tick();
        if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_frame_err_len: got %b want 0", frame_err); end
        checks++;
`endif
        repeat (3) tick();
        if (obs_rxv != 0) begin errors++; $display("FAIL abort_no_rxv: got %0d want 0", obs_rxv); end
        checks++;
        start_frame(1'b0);
        shift_bits(10'h0FF, FW);
        tick();
        if (rx_valid !== 1'b1 || rx_data !== 10'h0FF) begin
            errors++; $display("FAIL abort_recover: got v=%b d=%h want v=1 d=0ff", rx_valid, rx_data);
        end
        checks++;
        end_frame();
        model_rx = 10'h0FF;
        // Deselect on the same edge as the last bit.
        obs_rxv = 0;
        v = {1'b0, 9'($urandom)};
        start_frame(1'b0);
        shift_bits(v, FW - 1);
        tick(); MOSI = v[FW-1]; SS_n = 1'b1;
        repeat (3) tick();
        if (obs_rxv != 0 || rx_data !== model_rx) begin
            errors++; $display("FAIL abort_last_bit: got rxv=%0d d=%h want 0 %h", obs_rxv, rx_data, model_rx);
        end
        checks++;
        // Deselect on the same edge as tx_valid in a read-data frame.
        if (!model_raddr) begin
            start_frame(1'b1);
            shift_bits({2'b10, 8'($urandom)}, FW);
            end_frame();
            model_raddr = 1'b1;
        end
        v = {2'b11, 8'($urandom)};
        start_frame(1'b1);
        shift_bits(v, FW);
        tick();
        model_raddr = 1'b0;
        model_rx = v;
        obs_miso = 0;
        tx_valid = 1'b1; tx_data = 8'hFF; SS_n = 1'b1;
        tick(); tx_valid = 1'b0;
        repeat (10) tick();
        if (obs_miso != 0) begin errors++; $display("FAIL abort_tx_valid: got %0d want 0", obs_miso); end
        checks++;
    endtask

    task automatic test_timeout();
        logic [FW-1:0] d;
        int            found;
        if (!model_raddr) begin
            start_frame(1'b1);
            shift_bits({2'b10, 8'($urandom)}, FW);
            end_frame();
            model_raddr = 1'b1;
        end
        d = {2'b11, 8'($urandom)};
        start_frame(1'b1);
        shift_bits(d, FW);
        tick();
        if (rx_valid !== 1'b1 || rx_data !== d) begin
            errors++; $display("FAIL timeout_rx: got v=%b d=%h want v=1 d=%h", rx_valid, rx_data, d);
        end
        checks++;
        model_raddr = 1'b0;
        model_rx = d;
        obs_miso = 0;
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (tx_timeout === 1'b1) begin found = k; break; end
        end
        if (found != TWM) begin errors++; $display("FAIL timeout_delay: got %0d want %0d", found, TWM); end
        checks++;
        tick();
        if (tx_timeout !== 1'b0) begin errors++; $display("FAIL timeout_len: got %b want 0", tx_timeout); end
        checks++;
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tx_valid = 1'b0;
        repeat (10) tick();
        end_frame();
        if (obs_miso != 0) begin errors++; $display("FAIL timeout_miso: got %0d want 0", obs_miso); end
        checks++;
    endtask

    task automatic test_reset_mid_send();
        logic [FW-1:0] d;
        if (!model_raddr) begin
            start_frame(1'b1);
            shift_bits({2'b10, 8'($urandom)}, FW);
            end_frame();
            model_raddr = 1'b1;
        end
        d = {2'b11, 8'($urandom)};
        start_frame(1'b1);
        shift_bits(d, FW);
        tick();
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick(); tx_valid = 1'b0;
        tick(); tick();
        if (MISO !== 1'b1 || rx_data !== d) begin
            errors++; $display("FAIL rst_pre: got m=%b d=%h want m=1 d=%h", MISO, rx_data, d);
        end
        checks++;
        #2 rst_n = 1'b0;
        SS_n = 1'b1;
        #1;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0) begin
            errors++; $display("FAIL rst_async: got m=%b v=%b d=%h want 0 0 0", MISO, rx_valid, rx_data);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        model_raddr = 1'b0;
        model_rx = '0;
        // raddr_done must have been cleared: this read frame is an address frame.
        obs_miso = 0;
        start_frame(1'b1);
        shift_bits({2'b11, 8'($urandom)}, FW);
        tick();
        tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (4) tick();
        tx_valid = 1'b0;
        end_frame();
        if (obs_miso != 0) begin errors++; $display("FAIL rst_raddr_clear: got %0d want 0", obs_miso); end
        checks++;
        model_raddr = 1'b1;
    endtask

    task automatic test_msb_first();
        logic [FW2-1:0] v, a, d;
        logic [DW2-1:0] t;
        logic           exp;
        for (int r = 0; r < 3; r++) begin
            v = (r == 0) ? 18'h1_2345 : {1'b0, 17'($urandom)};
            a = {2'b10, 16'($urandom)};
            d = {2'b11, 16'($urandom)};
            t = (r == 0) ? 16'h8001 : 16'($urandom);
            start2(1'b0);
            shift2(v);
            tick();
            if (rx_valid2 !== 1'b1 || rx_data2 !== v) begin
                errors++; $display("FAIL msb_write: got v=%b d=%h want v=1 d=%h", rx_valid2, rx_data2, v);
            end
            checks++;
            end2();
            start2(1'b1);
            shift2(a);
            end2();
            start2(1'b1);
            shift2(d);
            tick();
            if (rx_data2 !== d) begin errors++; $display("FAIL msb_rdata: got %h want %h", rx_data2, d); end
            checks++;
            tx_valid2 = 1'b1; tx_data2 = t;
            for (int i = 0; i < DW2 + 2; i++) begin
                tick();
                exp = (i < DW2) ? t[DW2-1-i] : 1'b0;
                if (miso2 !== exp) begin errors++; $display("FAIL msb_miso[%0d]: got %b want %b", i, miso2, exp); end
                checks++;
                tx_valid2 = 1'b0;
            end
            end2();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_timeout();
        test_msb_first();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
